ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource among `N` requesters. Priority comes from a one-hot ring pointer that rotates past each winner. Grants are held until the owner signals completion, drops its request, or a hold timeout expires. The arbiter sits between the requesting agents and the shared datapath, and its registered grant vector drives the resource's select/enable.

---
 rtl/ring_arb_pkg.sv | 44 ++++
 rtl/ring_pointer.sv | 30 +++
 rtl/ring_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_ring_rr_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types, default sizes and one-hot helper functions for the ring
// round-robin arbiter.
package ring_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Default sizing for a typical instance.
   localparam int N        = 4;
   localparam int MAX_HOLD = 15;

   // Widest vector the helper functions operate on; callers zero-extend
   // narrower vectors and slice the result back down.
   localparam int MAX_N = 32;

   // Rotate the low 'width' bits of a one-hot vector left by one, wrapping
   // bit width-1 back to bit 0. Bits at and above 'width' come back zero.
   function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] onehot,
                                              input int              width);
      logic [MAX_N-1:0] rot;
      rot = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < width) begin
            rot[(i + 1) % width] = onehot[i];
         end
      end
      return rot;
   endfunction

   // Binary index of the set bit in a one-hot vector; 0 for an all-zero vector.
   function automatic int unsigned onehot2bin(input logic [MAX_N-1:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (onehot[i]) begin
            idx = idx | unsigned'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/ring_pointer.sv
// One-hot priority pointer for the ring arbiter. On release it moves one
// place past the outgoing owner, so that owner becomes lowest priority.
module ring_pointer
   import ring_arb_pkg::*;
#(
   parameter int N = ring_arb_pkg::N
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         load,
   input  logic [N-1:0] owner,
   output logic [N-1:0] ptr
);

   logic [MAX_N-1:0] rot;
   logic             unused_rot_hi;

   assign rot           = rotl1(MAX_N'(owner), N);
   assign unused_rot_hi = ^rot[MAX_N-1:N];

   // Pointer register: agent 0 holds top priority out of reset; moves only on release.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ptr <= N'(1);
      end else if (load) begin
         ptr <= rot[N-1:0];
      end
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters. A grant is
// held until the owner signals done, drops its request, or the hold limit
// forces it off. Every output is registered.
module ring_rr_arbiter
   import ring_arb_pkg::*;
#(
   parameter int N        = ring_arb_pkg::N,
   parameter int MAX_HOLD = ring_arb_pkg::MAX_HOLD,
   parameter int HOLD_W   = 4,
   parameter int ID_W     = 2
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    done,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_id,
   output logic            busy,
   output logic            timeout
);

   arb_state_t        state, state_nxt;
   logic [N-1:0]      ptr;
   logic [HOLD_W-1:0] hold, hold_nxt;
   logic [N-1:0]      grant_nxt;
   logic [ID_W-1:0]   grant_id_nxt;
   logic              busy_nxt;
   logic              timeout_nxt;
   logic              ptr_load;

   logic [2*N-1:0]    dbl_req;
   logic [2*N-1:0]    dbl_win;
   logic [N-1:0]      winner;
   logic              owner_done;
   logic              owner_req;
   logic              hold_max;

   // Doubling req lets a single subtract find the first request at or above
   // the pointer; a hit that wrapped past N-1 lands in the upper copy and is
   // folded back onto the lower one.
   assign dbl_req = {req, req};
   assign dbl_win = dbl_req & ~(dbl_req - {{N{1'b0}}, ptr});
   assign winner  = dbl_win[N-1:0] | dbl_win[2*N-1:N];

   assign owner_done = |(done & grant);
   assign owner_req  = |(req & grant);
   assign hold_max   = (hold == HOLD_W'(MAX_HOLD));

   ring_pointer #(
      .N (N)
   ) u_ptr (
      .Clock (Clock),
      .Reset (Reset),
      .load  (ptr_load),
      .owner (grant),
      .ptr   (ptr)
   );

   // Next-state and next-output decode for the IDLE/GRANT machine.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves one unassigned and infers a latch.
      state_nxt    = state;
      grant_nxt    = grant;
      grant_id_nxt = grant_id;
      busy_nxt     = busy;
      timeout_nxt  = 1'b0;
      hold_nxt     = hold;
      ptr_load     = 1'b0;

      unique case (state)
         IDLE: begin
            if (req != '0) begin
               state_nxt    = GRANT;
               grant_nxt    = winner;
               grant_id_nxt = ID_W'(onehot2bin(MAX_N'(winner)));
               busy_nxt     = 1'b1;
               hold_nxt     = HOLD_W'(1);
            end
         end

         GRANT: begin
            if (owner_done || !owner_req || hold_max) begin
               state_nxt    = IDLE;
               grant_nxt    = '0;
               grant_id_nxt = '0;
               busy_nxt     = 1'b0;
               hold_nxt     = '0;
               ptr_load     = 1'b1;
               // Forced release only when the owner would otherwise have kept it.
               timeout_nxt  = hold_max && !owner_done && owner_req;
            end else if (!hold_max) begin
               hold_nxt = hold + HOLD_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, hold counter and output registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         grant    <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         hold     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state    <= state_nxt;
         grant    <= grant_nxt;
         grant_id <= grant_id_nxt;
         busy     <= busy_nxt;
         timeout  <= timeout_nxt;
         hold     <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: directed scenarios followed by
// random traffic, all compared against an index-based behavioural model.
module tb_ring_rr_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 15;
   localparam int HOLD_W   = 4;
   localparam int ID_W     = 2;

   logic            Clock = 1'b0;
   logic            Reset;
   logic [N-1:0]    req;
   logic [N-1:0]    done;
   logic [N-1:0]    grant;
   logic [ID_W-1:0] grant_id;
   logic            busy;
   logic            timeout;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: owner and pointer kept as plain agent indices.
   bit m_busy;
   bit m_timeout;
   int m_owner;
   int m_ptr;
   int m_hold;

   always #5 Clock = ~Clock;

   ring_rr_arbiter #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W),
      .ID_W     (ID_W)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy    = 1'b0;
      m_timeout = 1'b0;
      m_owner   = 0;
      m_ptr     = 0;
      m_hold    = 0;
   endtask

   // One rising edge of the arbiter as described in words: scan from the
   // pointer upward with wrap, hold until done/drop/limit, then move past owner.
   task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
      m_timeout = 1'b0;
      if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            if (!m_busy && r[(m_ptr + k) % N]) begin
               m_busy  = 1'b1;
               m_owner = (m_ptr + k) % N;
               m_hold  = 1;
            end
         end
      end else begin
         if (d[m_owner] || !r[m_owner] || m_hold == MAX_HOLD) begin
            m_timeout = !d[m_owner] && r[m_owner];
            m_ptr     = (m_owner + 1) % N;
            m_busy    = 1'b0;
            m_owner   = 0;
            m_hold    = 0;
         end else begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".grant"},    32'(grant),    m_busy ? (32'd1 << m_owner) : 32'd0);
      check({tag, ".grant_id"}, 32'(grant_id), m_busy ? 32'(m_owner) : 32'd0);
      check({tag, ".busy"},     32'(busy),     32'(m_busy));
      check({tag, ".timeout"},  32'(timeout),  32'(m_timeout));
      check({tag, ".ptr"},      32'(dut.ptr),  32'd1 << m_ptr);
   endtask

   // Drive inputs, take one edge, update the model, sample 1 time unit later.
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input string tag);
      req  = r;
      done = d;
      @(posedge Clock);
      model_edge(r, d);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      req   = '0;
      done  = '0;
      Reset = 1'b1;
      model_reset();
      #1;
      check_all("reset");
      @(posedge Clock);
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      logic [N-1:0] order[5];
      logic [N-1:0] last_grant;
      logic [N-1:0] r;
      logic [N-1:0] d;
      int           k;
      int           cnt;
      int           pulses;

      // Single request: grant after one edge, done moves pointer past owner.
      do_reset();
      step(4'b0100, 4'b0000, "t1_grant");
      check("t1_id", 32'(grant_id), 32'd2);
      step(4'b0100, 4'b0100, "t1_release");
      check("t1_ptr", 32'(dut.ptr), 32'b1000);
      step(4'b0000, 4'b0000, "t1_idle");

      // All requesting, each owner releases after two grant cycles.
      do_reset();
      order      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      last_grant = '0;
      k          = 0;
      for (int i = 0; i < 15; i++) begin
         d = (m_busy && m_hold == 2) ? N'(1 << m_owner) : '0;
         step(4'b1111, d, "t2_rr");
         if (grant != '0 && grant != last_grant && k < 5) begin
            check("t2_order", 32'(grant), 32'(order[k]));
            k++;
         end
         last_grant = grant;
      end
      check("t2_count", 32'(k), 32'd5);

      // Held request without done: forced release after MAX_HOLD cycles.
      do_reset();
      cnt    = 0;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         step(4'b0001, 4'b0000, "t3_hold");
         if (grant == 4'b0001) cnt++;
         if (timeout) pulses++;
      end
      check("t3_cycles", 32'(cnt), 32'(MAX_HOLD));
      check("t3_pulses", 32'(pulses), 32'd1);
      check("t3_ptr", 32'(dut.ptr), 32'b0010);
      step(4'b0001, 4'b0000, "t3_regrant");
      check("t3_regrant_grant", 32'(grant), 32'b0001);

      // Non-owner done ignored; owner dropping req releases without timeout.
      do_reset();
      step(4'b0010, 4'b0000, "t4_grant");
      step(4'b0010, 4'b0100, "t4_nonowner");
      step(4'b0010, 4'b0100, "t4_nonowner2");
      check("t4_still", 32'(grant), 32'b0010);
      step(4'b0000, 4'b0000, "t4_drop");
      check("t4_timeout", 32'(timeout), 32'd0);

      // Done on the same edge the hold limit is reached: normal release.
      do_reset();
      step(4'b0001, 4'b0000, "t5_grant");
      for (int i = 0; i < MAX_HOLD - 1; i++) begin
         step(4'b0001, 4'b0000, "t5_hold");
      end
      check("t5_at_max", 32'(grant), 32'b0001);
      step(4'b0001, 4'b0001, "t5_done_at_max");
      check("t5_timeout", 32'(timeout), 32'd0);
      check("t5_grant", 32'(grant), 32'd0);

      // Asynchronous reset between edges while a grant is held.
      do_reset();
      step(4'b0001, 4'b0000, "t6_grant");
      #2;
      Reset = 1'b1;
      model_reset();
      #1;
      check_all("t6_async");
      #2;
      Reset = 1'b0;
      step(4'b1010, 4'b0000, "t6_after");
      check("t6_grant", 32'(grant), 32'b0010);

      // Random traffic: loose requests with random drops and done strobes.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 1) == 1) ? req : N'($urandom);
         d = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         step(r, d, "rnd_loose");
      end

      // Random traffic: all requesting, rare done, so timeouts occur.
      for (int i = 0; i < 300; i++) begin
         d = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
         step(4'b1111, d, "rnd_full");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
